// File: rtl/mem_stage_pkg.sv
// Shared bus layouts and load-op encoding for the EX -> MEM -> WB boundary.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 77;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_TO_DS_BYPASS = 39;

    // ld_op is one-hot, ordered {b, bu, h, hu, w} from MSB down.
    localparam int LD_B  = 4;
    localparam int LD_BU = 3;
    localparam int LD_H  = 2;
    localparam int LD_HU = 1;
    localparam int LD_W  = 0;

    typedef struct packed {
        logic [4:0]  ld_op;
        logic        req_issued;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        we;
        logic        load_pending;
        logic [4:0]  dest;
        logic [31:0] result;
    } ms_to_ds_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load data alignment and sign/zero extension; zero latency.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [4:0]  ld_op,
    input  logic [1:0]  off,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[8*off +: 8];
        // Halfword misalignment is trapped upstream, so off[0] is ignored.
        half_sel = off[1] ? raw[31:16] : raw[15:0];
        result   = raw;
        if (ld_op[LD_B])
            result = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_op[LD_BU])
            result = {24'd0, byte_sel};
        else if (ld_op[LD_H])
            result = {{16{half_sel[15]}}, half_sel};
        else if (ld_op[LD_HU])
            result = {16'd0, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: non-memory ops take 1 cycle, loads leave the cycle data_ok arrives.
// Backpressure: holds while waiting for data_ok or !ws_allowin; buffers a response that WB cannot take yet.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       ws_allowin,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_TO_DS_BYPASS-1:0] ms_to_ds_bypass
);

    logic        ms_valid;
    es_to_ms_t   ms_bus_r;
    logic [31:0] rdata_buf;
    logic        rdata_buf_vld;

    logic        ms_ready_go;
    logic        resp_ok;
    logic [31:0] raw_word;
    logic [31:0] aligned_load;
    logic [31:0] final_result;
    ms_to_ws_t   ws_bus;
    ms_to_ds_t   ds_bus;

    // A response only counts when a valid instruction actually issued a request.
    assign resp_ok        = ms_valid & ms_bus_r.req_issued & data_sram_data_ok;
    assign ms_ready_go    = !(ms_valid & ms_bus_r.req_issued) | data_sram_data_ok | rdata_buf_vld;
    assign ms_allowin     = !ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
            ms_bus_r <= '0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
            if (es_to_ms_valid)
                ms_bus_r <= es_to_ms_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_buf_vld <= 1'b0;
            rdata_buf     <= '0;
        end else if (ms_to_ws_valid & ws_allowin) begin
            rdata_buf_vld <= 1'b0;
        end else if (resp_ok & !rdata_buf_vld & !ws_allowin) begin
            rdata_buf_vld <= 1'b1;
            rdata_buf     <= data_sram_rdata;
        end
    end

    assign raw_word = rdata_buf_vld ? rdata_buf : data_sram_rdata;

    mem_load_align u_align (
        .ld_op  (ms_bus_r.ld_op),
        .off    (ms_bus_r.alu_result[1:0]),
        .raw    (raw_word),
        .result (aligned_load)
    );

    assign final_result = ms_bus_r.res_from_mem ? aligned_load : ms_bus_r.alu_result;

    always_comb begin
        ws_bus.gr_we        = ms_bus_r.gr_we;
        ws_bus.dest         = ms_bus_r.dest;
        ws_bus.final_result = final_result;
        ws_bus.pc           = ms_bus_r.pc;
        ds_bus.we           = ms_valid & ms_bus_r.gr_we;
        ds_bus.load_pending = ms_valid & ms_bus_r.res_from_mem & !ms_ready_go;
        ds_bus.dest         = ms_bus_r.dest;
        ds_bus.result       = final_result;
    end

    assign ms_to_ws_bus    = ws_bus;
    assign ms_to_ds_bypass = ds_bus;

endmodule
